// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one 2:1 data mux between requesters A and B.
// Latency: 1 cycle to grant from IDLE, then 1 cycle from accept to out_valid, 1 beat/cycle sustained.
// Backpressure: readies open only when the output slot is empty or draining; out_ready never reaches out_* combinationally.
module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  output logic             busy
);

  // Burst counter only has to hold 0..BURST_MAX-1; keep at least one bit.
  localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_A = 2'd1;
  localparam logic [1:0] SERVE_B = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ptr;       // 0 = A has priority on a tie, 1 = B
  logic             ptr_nxt;
  logic             sel_nxt;
  logic             slot_free;
  logic             a_acc;
  logic             b_acc;
  logic             x_acc;
  logic             serving_b;
  logic             x_valid;
  logic             y_valid;
  logic [WIDTH-1:0] mux_data;

  // Handshake readies: the granted side may push whenever the output slot can take a beat.
  always_comb begin
    slot_free = !out_valid || out_ready;
    a_ready   = (state == SERVE_A) && slot_free;
    b_ready   = (state == SERVE_B) && slot_free;
    a_acc     = a_valid && a_ready;
    b_acc     = b_valid && b_ready;
    x_acc     = a_acc || b_acc;
    serving_b = (state == SERVE_B);
    x_valid   = serving_b ? b_valid : a_valid;
    y_valid   = serving_b ? a_valid : b_valid;
    mux_data  = sel ? b_data : a_data;
    busy      = (state != IDLE);
  end

  // Grant FSM: pick a side from IDLE, then hand over at a burst boundary or when the owner goes quiet.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (a_valid && b_valid) begin
          state_nxt = ptr ? SERVE_B : SERVE_A;
        end else if (a_valid) begin
          state_nxt = SERVE_A;
        end else if (b_valid) begin
          state_nxt = SERVE_B;
        end
      end
      SERVE_A, SERVE_B: begin
        if (x_acc && (cnt == CNT_LAST)) begin
          // Burst limit reached: hand over only if the other side is waiting.
          cnt_nxt = '0;
          if (y_valid) begin
            state_nxt = serving_b ? SERVE_A : SERVE_B;
            ptr_nxt   = !serving_b;
          end
        end else if (!x_valid) begin
          // Owner ran dry: the other side gets priority next regardless.
          cnt_nxt   = '0;
          ptr_nxt   = !serving_b;
          state_nxt = y_valid ? (serving_b ? SERVE_A : SERVE_B) : IDLE;
        end else if (x_acc) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Mux select follows the grant and keeps the last owner while idle.
  always_comb begin
    sel_nxt = sel;
    if (state_nxt == SERVE_A) begin
      sel_nxt = 1'b0;
    end else if (state_nxt == SERVE_B) begin
      sel_nxt = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= 1'b0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
    end
  end

  // Output slot: load on accept, empty when drained, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (x_acc) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic against a reference model.
// Latency: model steps on each rising edge; DUT outputs are sampled 1 time unit after the falling edge.
// Backpressure: out_ready is driven as stimulus, including random stalls.
module tb_mux_rr_arbiter;

  localparam int WIDTH     = 8;
  localparam int BURST_MAX = 4;
  localparam int NONE      = 2;   // model owner value when nobody holds the grant

  logic             clk = 1'b0;
  logic             rst;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             sel;
  logic             busy;

  int checks = 0;
  int passed = 0;

  mux_rr_arbiter #(.WIDTH(WIDTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: who owns the grant, beats taken in this turn, who wins a tie, and the output slot.
  typedef struct packed {
    int               owner;  // 0 = A, 1 = B, NONE = idle
    int               beats;
    int               prio;
    logic             ov;
    logic [WIDTH-1:0] od;
    logic             msel;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic r, logic av, logic [WIDTH-1:0] ad,
                                        logic bv, logic [WIDTH-1:0] bd, logic ordy);
    model_t n;
    logic   room, took_a, took_b, mine_v, other_v;
    int     other;
    n = c;
    if (r) begin
      n.owner = NONE; n.beats = 0; n.prio = 0; n.ov = 1'b0; n.od = '0; n.msel = 1'b0;
      return n;
    end
    room   = !c.ov || ordy;
    took_a = (c.owner == 0) && room && av;
    took_b = (c.owner == 1) && room && bv;
    if (took_a) begin
      n.ov = 1'b1; n.od = ad;
    end else if (took_b) begin
      n.ov = 1'b1; n.od = bd;
    end else if (ordy) begin
      n.ov = 1'b0;
    end
    if (c.owner == NONE) begin
      if (av && bv) n.owner = c.prio;
      else if (av)  n.owner = 0;
      else if (bv)  n.owner = 1;
    end else begin
      mine_v  = (c.owner == 0) ? av : bv;
      other_v = (c.owner == 0) ? bv : av;
      other   = 1 - c.owner;
      if ((took_a || took_b) && (c.beats + 1 == BURST_MAX)) begin
        n.beats = 0;
        if (other_v) begin
          n.owner = other; n.prio = other;
        end
      end else if (!mine_v) begin
        n.beats = 0;
        n.prio  = other;
        n.owner = other_v ? other : NONE;
      end else begin
        n.beats = c.beats + ((took_a || took_b) ? 1 : 0);
      end
    end
    if (n.owner != NONE) n.msel = (n.owner == 1);
    return n;
  endfunction

  // Advance the model on the same edge the DUT samples.
  always @(posedge clk) m <= model_next(m, rst, a_valid, a_data, b_valid, b_data, out_ready);

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data); else passed++;
    checks++; if (sel !== 1'b0) $display("FAIL reset_sel got %b want 0", sel); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL reset_readies got %b want 00", {a_ready, b_ready}); else passed++;
  endtask

  task automatic test_a_only();
    do_reset();
    a_valid = 1'b1; a_data = 8'h11; out_ready = 1'b1;
    #1;
    checks++; if ({busy, a_ready} !== 2'b00) $display("FAIL a_only_idle got busy/ready %b want 00", {busy, a_ready}); else passed++;
    @(negedge clk); #1;
    checks++; if ({busy, a_ready, sel} !== 3'b110) $display("FAIL a_only_grant got %b want 110", {busy, a_ready, sel}); else passed++;
    @(negedge clk); a_data = 8'h22; #1;
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h11}) $display("FAIL a_only_beat1 got %b/%h want 1/11", out_valid, out_data); else passed++;
    @(negedge clk); a_data = 8'h33; #1;
    checks++; if ({out_valid, out_data} !== {1'b1, 8'h22}) $display("FAIL a_only_beat2 got %b/%h want 1/22", out_valid, out_data); else passed++;
    @(negedge clk); a_valid = 1'b0; #1;
    checks++; if ({out_valid, out_data, sel} !== {1'b1, 8'h33, 1'b0}) $display("FAIL a_only_beat3 got %b/%h/%b want 1/33/0", out_valid, out_data, sel); else passed++;
    @(negedge clk); #1;
    checks++; if ({busy, out_valid, sel} !== 3'b000) $display("FAIL a_only_idle_again got %b want 000", {busy, out_valid, sel}); else passed++;
  endtask

  task automatic test_round_robin();
    int na = 0, nb = 0;
    logic pa = 1'b0, pb = 1'b0, prev_acc = 1'b0;
    logic [WIDTH-1:0] prev_dat = '0;
    int seq[$];
    int cyc_of[$];
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pa) begin na++; a_data = 8'(8'hA0 + na); end
      if (pb) begin nb++; b_data = 8'(8'hB0 + nb); end
      #1;
      if (prev_acc) begin
        checks++;
        if ({out_valid, out_data} !== {1'b1, prev_dat})
          $display("FAIL rr_out cyc %0d got %b/%h want 1/%h", cyc, out_valid, out_data, prev_dat);
        else passed++;
      end
      pa = a_valid && a_ready;
      pb = b_valid && b_ready;
      prev_acc = pa || pb;
      prev_dat = pb ? b_data : a_data;
      if (pa || pb) begin
        seq.push_back(pb ? 1 : 0);
        cyc_of.push_back(cyc);
        checks++;
        if (sel !== pb) $display("FAIL rr_sel cyc %0d got %b want %b", cyc, sel, pb); else passed++;
      end
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= seq.size() || seq[i] != (i / 4) % 2)
        $display("FAIL rr_order[%0d] got %0d want %0d", i, (i < seq.size()) ? seq[i] : -1, (i / 4) % 2);
      else passed++;
    end
    checks++;
    if (cyc_of.size() < 12 || cyc_of[11] - cyc_of[0] != 11)
      $display("FAIL rr_no_bubble got %0d accepts span %0d want 12 span 11", cyc_of.size(),
               (cyc_of.size() >= 12) ? cyc_of[11] - cyc_of[0] : -1);
    else passed++;
  endtask

  task automatic test_backpressure();
    int sent = 0, npop = 0;
    logic pa = 1'b0;
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] want;
    do_reset();
    a_valid = 1'b1; a_data = 8'hC0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pa) begin
        sent++;
        if (sent < 5) a_data = 8'(8'hC0 + sent); else a_valid = 1'b0;
      end
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (!out_ready && out_valid) begin
        checks++;
        if (q.size() == 0 || out_data !== q[0] || {a_ready, b_ready} !== 2'b00)
          $display("FAIL bp_hold cyc %0d got %h rdy %b want %h rdy 00", cyc, out_data, {a_ready, b_ready},
                   (q.size() > 0) ? q[0] : 8'h00);
        else passed++;
      end
      if (out_valid && out_ready) begin
        want = (q.size() > 0) ? q.pop_front() : 8'hxx;
        npop++;
        checks++;
        if (out_data !== want) $display("FAIL bp_order cyc %0d got %h want %h", cyc, out_data, want); else passed++;
      end
      pa = a_valid && a_ready;
      if (pa) q.push_back(a_data);
    end
    checks++;
    if (npop != 5 || q.size() != 0) $display("FAIL bp_count got %0d pops %0d left want 5 pops 0 left", npop, q.size());
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    a_valid = 1'b0; b_valid = 1'b1; b_data = 8'hB0; out_ready = 1'b1;
    #1;
    @(negedge clk); #1;
    checks++; if (b_ready !== 1'b1) $display("FAIL rmb_beat1 got b_ready %b want 1", b_ready); else passed++;
    @(negedge clk); b_data = 8'hB1; #1;
    checks++;
    if ({b_ready, out_valid, out_data, sel} !== {1'b1, 1'b1, 8'hB0, 1'b1})
      $display("FAIL rmb_beat2 got %b/%b/%h/%b want 1/1/b0/1", b_ready, out_valid, out_data, sel);
    else passed++;
    @(negedge clk); rst = 1'b1; a_valid = 1'b1; #1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({out_valid, out_data, sel, busy, a_ready, b_ready} !== {1'b0, 8'h00, 4'b0000})
      $display("FAIL rmb_after_reset got %b/%h/%b/%b/%b/%b want 0/00/0/0/0/0", out_valid, out_data, sel, busy, a_ready, b_ready);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({sel, a_ready, b_ready, busy} !== 4'b0101)
      $display("FAIL rmb_tie_to_a got sel/ar/br/busy %b want 0101", {sel, a_ready, b_ready, busy});
    else passed++;
  endtask

  task automatic test_b_stream();
    int nb = 0;
    logic pb = 1'b0;
    do_reset();
    a_valid = 1'b0; a_data = 8'hAA; b_valid = 1'b1; b_data = 8'h50; out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pb) begin nb++; b_data = 8'(8'h50 + nb); end
      if (nb >= 4) a_valid = 1'b1;
      #1;
      pb = b_valid && b_ready;
      if (cyc >= 1 && cyc <= 8) begin
        checks++;
        if ({pb, sel, busy, a_ready} !== 4'b1110)
          $display("FAIL bs_serve_b cyc %0d got acc/sel/busy/ar %b want 1110", cyc, {pb, sel, busy, a_ready});
        else passed++;
      end else if (cyc == 9) begin
        checks++;
        if ({a_ready, b_ready, sel} !== 3'b100)
          $display("FAIL bs_handover got ar/br/sel %b want 100", {a_ready, b_ready, sel});
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    logic pa = 1'b0, pb = 1'b0;
    logic ea, eb;
    int   dens;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      dens = (cyc < 300) ? 3 : 1;
      rst = ($urandom_range(0, 79) == 0);
      if (!a_valid || pa) begin a_valid = ($urandom_range(0, 3) < dens); a_data = 8'($urandom); end
      if (!b_valid || pb) begin b_valid = ($urandom_range(0, 3) < dens); b_data = 8'($urandom); end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ea = (m.owner == 0) && (!m.ov || out_ready);
      eb = (m.owner == 1) && (!m.ov || out_ready);
      checks++; if (a_ready !== ea) $display("FAIL rnd_a_ready cyc %0d got %b want %b", cyc, a_ready, ea); else passed++;
      checks++; if (b_ready !== eb) $display("FAIL rnd_b_ready cyc %0d got %b want %b", cyc, b_ready, eb); else passed++;
      checks++; if (out_valid !== m.ov) $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, out_valid, m.ov); else passed++;
      checks++; if (out_data !== m.od) $display("FAIL rnd_out_data cyc %0d got %h want %h", cyc, out_data, m.od); else passed++;
      checks++; if (sel !== m.msel) $display("FAIL rnd_sel cyc %0d got %b want %b", cyc, sel, m.msel); else passed++;
      checks++; if (busy !== (m.owner != NONE)) $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy, m.owner != NONE); else passed++;
      pa = a_valid && a_ready && !rst;
      pb = b_valid && b_ready && !rst;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_round_robin();
    test_backpressure();
    test_reset_mid_burst();
    test_b_stream();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
